// File: rtl/cpu_issue_ctrl.sv
// Issue sequencer for R-type instruction words: accepts one instruction, drives the
// datapath controls for a single cycle, then returns the captured ALU result.
module cpu_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [4:0]       read_reg1,
  output logic [4:0]       read_reg2,
  output logic [4:0]       write_reg,
  output logic [3:0]       ALU_Sel,
  output logic [4:0]       Shamt,
  output logic             write_enable,
  input  logic [31:0]      ALU_result,
  input  logic             Zero_flag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_zero,
  output logic             resp_illegal,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic [31:0]       instr_q;
  logic              instr_ready_q;
  logic              resp_valid_q;
  logic [31:0]       resp_data_q;
  logic              resp_zero_q;
  logic              resp_illegal_q;
  logic [CNT_W-1:0]  retired_cnt_q;
  logic [CNT_W-1:0]  retired_cnt_d;
  logic [CNT_W-1:0]  illegal_cnt_q;
  logic [CNT_W-1:0]  illegal_cnt_d;

  logic              dec_legal;
  logic [3:0]        dec_sel;
  logic              in_exec;

  // Decode works only on the latched word, so instr never reaches the datapath directly.
  always_comb begin
    dec_legal = 1'b0;
    dec_sel   = 4'd0;
    if (instr_q[31:26] == 6'h00) begin
      dec_legal = 1'b1;
      case (instr_q[5:0])
        6'h20:   dec_sel = 4'd0;
        6'h22:   dec_sel = 4'd1;
        6'h24:   dec_sel = 4'd2;
        6'h25:   dec_sel = 4'd3;
        6'h26:   dec_sel = 4'd4;
        6'h27:   dec_sel = 4'd5;
        6'h00:   dec_sel = 4'd6;
        6'h02:   dec_sel = 4'd7;
        6'h03:   dec_sel = 4'd8;
        6'h2A:   dec_sel = 4'd9;
        default: dec_legal = 1'b0;
      endcase
    end
  end

  assign in_exec = (state_q == EXEC);

  always_comb begin
    read_reg1    = 5'd0;
    read_reg2    = 5'd0;
    write_reg    = 5'd0;
    Shamt        = 5'd0;
    ALU_Sel      = 4'd0;
    write_enable = 1'b0;
    if (in_exec) begin
      read_reg1    = instr_q[25:21];
      read_reg2    = instr_q[20:16];
      write_reg    = instr_q[15:11];
      Shamt        = instr_q[10:6];
      ALU_Sel      = dec_legal ? dec_sel : 4'd0;
      // Writes to r0 are dropped here but the instruction still retires.
      write_enable = dec_legal && (instr_q[15:11] != 5'd0);
    end
  end

  // Saturating counters: hold at all-ones rather than wrapping.
  always_comb begin
    retired_cnt_d = retired_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (in_exec) begin
      if (dec_legal) begin
        if (retired_cnt_q != {CNT_W{1'b1}}) retired_cnt_d = retired_cnt_q + CNT_W'(1);
      end else begin
        if (illegal_cnt_q != {CNT_W{1'b1}}) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      instr_q        <= 32'd0;
      instr_ready_q  <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= 32'd0;
      resp_zero_q    <= 1'b0;
      resp_illegal_q <= 1'b0;
      retired_cnt_q  <= '0;
      illegal_cnt_q  <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
      case (state_q)
        IDLE: begin
          instr_ready_q <= 1'b1;
          if (instr_valid && instr_ready_q) begin
            instr_q       <= instr;
            instr_ready_q <= 1'b0;
            state_q       <= EXEC;
          end
        end
        EXEC: begin
          resp_valid_q   <= 1'b1;
          resp_data_q    <= dec_legal ? ALU_result : 32'd0;
          resp_zero_q    <= dec_legal && Zero_flag;
          resp_illegal_q <= !dec_legal;
          state_q        <= RESP;
        end
        RESP: begin
          // Ready returns with the IDLE state, so no accept overlaps the response handshake.
          if (resp_ready) begin
            resp_valid_q  <= 1'b0;
            instr_ready_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q       <= IDLE;
          instr_ready_q <= 1'b0;
          resp_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready  = instr_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_zero    = resp_zero_q;
  assign resp_illegal = resp_illegal_q;
  assign retired_cnt  = retired_cnt_q;
  assign illegal_cnt  = illegal_cnt_q;

endmodule

// File: tb/tb_cpu_issue_ctrl.sv
// Randomized bench for cpu_issue_ctrl; a 16-bit and a 2-bit counter instance share stimulus.
module tb_cpu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, instr_valid, resp_ready, Zero_flag;
  logic [31:0] instr, ALU_result;

  logic        ready_a, we_a, rv_a, rz_a, ri_a;
  logic [4:0]  rr1_a, rr2_a, wr_a, sh_a;
  logic [3:0]  sel_a;
  logic [31:0] rd_a;
  logic [15:0] ret_a, ill_a;

  logic        ready_b, we_b, rv_b, rz_b, ri_b;
  logic [4:0]  rr1_b, rr2_b, wr_b, sh_b;
  logic [3:0]  sel_b;
  logic [31:0] rd_b;
  logic [1:0]  ret_b, ill_b;

  cpu_issue_ctrl #(.CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(ready_a),
    .read_reg1(rr1_a), .read_reg2(rr2_a), .write_reg(wr_a), .ALU_Sel(sel_a), .Shamt(sh_a),
    .write_enable(we_a), .ALU_result(ALU_result), .Zero_flag(Zero_flag),
    .resp_valid(rv_a), .resp_ready(resp_ready), .resp_data(rd_a), .resp_zero(rz_a),
    .resp_illegal(ri_a), .retired_cnt(ret_a), .illegal_cnt(ill_a)
  );

  cpu_issue_ctrl #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(ready_b),
    .read_reg1(rr1_b), .read_reg2(rr2_b), .write_reg(wr_b), .ALU_Sel(sel_b), .Shamt(sh_b),
    .write_enable(we_b), .ALU_result(ALU_result), .Zero_flag(Zero_flag),
    .resp_valid(rv_b), .resp_ready(resp_ready), .resp_data(rd_b), .resp_zero(rz_b),
    .resp_illegal(ri_b), .retired_cnt(ret_b), .illegal_cnt(ill_b)
  );

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;
  int exp_ill = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Legal R-type functs in ALU_Sel order: the position in this list is the select code.
  logic [5:0] funct_tab [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h2A};

  function automatic void ref_decode(input logic [31:0] w, output bit legal, output logic [3:0] sel);
    legal = 1'b0;
    sel   = 4'd0;
    if (w[31:26] == 6'h00)
      for (int k = 0; k < 10; k++)
        if (w[5:0] == funct_tab[k]) begin
          legal = 1'b1;
          sel   = 4'(k);
        end
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic apply_reset();
    rst = 1'b1; instr_valid = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;
    exp_ill = 0;
    @(negedge clk);
  endtask

  task automatic run_txn(input string tag, input logic [31:0] w, input logic [31:0] alu,
                         input logic z, input int stall);
    bit          legal;
    logic [3:0]  sel;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_zero;
    int          t;
    ref_decode(w, legal, sel);
    exp_we   = legal && (w[15:11] != 5'd0);
    exp_data = legal ? alu : 32'd0;
    exp_zero = legal && z;
    instr = w; instr_valid = 1'b1; ALU_result = alu; Zero_flag = z; resp_ready = 1'b0;
    t = 0;
    while (ready_a !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (ready_a !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_timeout instr_ready=%b required 1", tag, ready_a);
      instr_valid = 1'b0;
      return;
    end
    checks++;
    if (we_a !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_we got %b required 0", tag, we_a);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    instr = $urandom;
    checks++;
    if ({rr1_a, rr2_a, wr_a, sel_a, sh_a, we_a, ready_a} !==
        {w[25:21], w[20:16], w[15:11], sel, w[10:6], exp_we, 1'b0}) begin
      errors++;
      $display("FAIL %s exec_ctrl got rs=%0d rt=%0d rd=%0d sel=%0d sh=%0d we=%b rdy=%b required rs=%0d rt=%0d rd=%0d sel=%0d sh=%0d we=%b rdy=0",
               tag, rr1_a, rr2_a, wr_a, sel_a, sh_a, we_a, ready_a,
               w[25:21], w[20:16], w[15:11], sel, w[10:6], exp_we);
    end
    if (legal) exp_ret++;
    else       exp_ill++;
    @(negedge clk);
    ALU_result = $urandom;
    Zero_flag  = ~z;
    checks++;
    if ({rv_a, rd_a, rz_a, ri_a, we_a} !== {1'b1, exp_data, exp_zero, !legal, 1'b0}) begin
      errors++;
      $display("FAIL %s resp got v=%b d=%h z=%b ill=%b we=%b required v=1 d=%h z=%b ill=%b we=0",
               tag, rv_a, rd_a, rz_a, ri_a, we_a, exp_data, exp_zero, !legal);
    end
    checks++;
    if ({ret_a, ill_a, ret_b, ill_b} !== {16'(exp_ret), 16'(exp_ill), 2'(sat3(exp_ret)), 2'(sat3(exp_ill))}) begin
      errors++;
      $display("FAIL %s counters got ret=%0d ill=%0d ret2=%0d ill2=%0d required %0d %0d %0d %0d",
               tag, ret_a, ill_a, ret_b, ill_b, exp_ret, exp_ill, sat3(exp_ret), sat3(exp_ill));
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checks++;
      if ({rv_a, rd_a, rz_a, ri_a, ready_a} !== {1'b1, exp_data, exp_zero, !legal, 1'b0}) begin
        errors++;
        $display("FAIL %s stall%0d got v=%b d=%h z=%b ill=%b rdy=%b required v=1 d=%h z=%b ill=%b rdy=0",
                 tag, s, rv_a, rd_a, rz_a, ri_a, ready_a, exp_data, exp_zero, !legal);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if ({rv_a, ready_a} !== 2'b01) begin
      errors++;
      $display("FAIL %s release got resp_valid=%b instr_ready=%b required 0 1", tag, rv_a, ready_a);
    end
    $display("txn %s instr=%h legal=%0d data=%h ret=%0d ill=%0d", tag, w, legal, exp_data, exp_ret, exp_ill);
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; resp_ready = 1'b0;
    instr = 32'd0; ALU_result = 32'd0; Zero_flag = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ready_a, we_a, rv_a, rd_a, rz_a, ri_a, rr1_a, rr2_a, wr_a, sel_a, sh_a, ret_a, ill_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b we=%b v=%b d=%h ret=%0d ill=%0d required all 0",
               ready_a, we_a, rv_a, rd_a, ret_a, ill_a);
    end
    rst = 1'b0;
    exp_ret = 0;
    exp_ill = 0;
    @(negedge clk);
    checks++;
    if (ready_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b required 1", ready_a);
    end
  endtask

  task automatic test_legal_add();
    run_txn("add", 32'h00221820, 32'h5, 1'b0, 0);
  endtask

  task automatic test_shift();
    run_txn("sll", 32'h00021100, 32'h0, 1'b1, 0);
  endtask

  task automatic test_illegal_rd0();
    run_txn("illegal_op", mk(6'h23, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'hDEAD_BEEF, 1'b1, 1);
    run_txn("illegal_funct", mk(6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h21), 32'h1234, 1'b1, 0);
    run_txn("rd0", 32'h00220020, 32'h77, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_txn("backpressure", mk(6'h00, 5'd7, 5'd8, 5'd9, 5'd0, 6'h26), 32'hA5A5_0F0F, 1'b0, 5);
  endtask

  task automatic test_back_to_back();
    int          acc [4];
    logic [31:0] exp_q [$];
    logic [31:0] w, alu, exp_d;
    int          t;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w   = mk(6'h00, 5'($urandom), 5'($urandom), 5'($urandom_range(1, 31)), 5'($urandom),
               funct_tab[$urandom_range(0, 9)]);
      alu = $urandom;
      instr = w; instr_valid = 1'b1; ALU_result = alu; Zero_flag = 1'b0;
      t = 0;
      while (ready_a !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (ready_a !== 1'b1) begin
        errors++;
        $display("FAIL b2b accept_timeout idx=%0d instr_ready=%b required 1", i, ready_a);
        instr_valid = 1'b0;
        resp_ready = 1'b0;
        return;
      end
      acc[i] = cyc;
      exp_q.push_back(alu);
      exp_ret++;
      if (i > 0) begin
        checks++;
        if (acc[i] - acc[i-1] != 3) begin
          errors++;
          $display("FAIL b2b spacing idx=%0d got %0d cycles required 3", i, acc[i] - acc[i-1]);
        end
      end
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      exp_d = exp_q.pop_front();
      checks++;
      if ({rv_a, rd_a} !== {1'b1, exp_d}) begin
        errors++;
        $display("FAIL b2b resp idx=%0d got v=%b d=%h required v=1 d=%h", i, rv_a, rd_a, exp_d);
      end
      $display("txn b2b%0d instr=%h cycle=%0d data=%h", i, w, acc[i], exp_d);
    end
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if ({ret_a, ret_b} !== {16'(exp_ret), 2'(sat3(exp_ret))}) begin
      errors++;
      $display("FAIL b2b counters got %0d %0d required %0d %0d", ret_a, ret_b, exp_ret, sat3(exp_ret));
    end
  endtask

  task automatic test_random();
    logic [5:0]  op, fn;
    logic [4:0]  rd;
    logic [31:0] w;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : funct_tab[$urandom_range(0, 9)];
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      w  = mk(op, 5'($urandom), 5'($urandom), rd, 5'($urandom), fn);
      run_txn($sformatf("rnd%0d", i), w, ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom),
              1'($urandom), $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid_exec();
    int t;
    instr = mk(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    instr_valid = 1'b1; resp_ready = 1'b0;
    t = 0;
    while (ready_a !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    checks++;
    if (we_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_exec precondition we got %b required 1", we_a);
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;
    exp_ill = 0;
    @(negedge clk);
    checks++;
    if ({we_a, rv_a, ready_a, ret_a, ill_a, ret_b, ill_b} !== {1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL rst_exec got we=%b v=%b rdy=%b ret=%0d ill=%0d required we=0 v=0 rdy=1 ret=0 ill=0",
               we_a, rv_a, ready_a, ret_a, ill_a);
    end
    $display("txn reset_mid_exec we=%b resp_valid=%b ready=%b", we_a, rv_a, ready_a);
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 5; i++)
      run_txn($sformatf("sat%0d", i), mk(6'h00, 5'($urandom), 5'($urandom), 5'($urandom_range(1, 31)),
              5'($urandom), funct_tab[$urandom_range(0, 9)]), $urandom, 1'b0, 0);
    checks++;
    if ({ret_a, ret_b} !== {16'd5, 2'd3}) begin
      errors++;
      $display("FAIL saturation got ret=%0d ret2=%0d required 5 3", ret_a, ret_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_legal_add();
    test_shift();
    test_illegal_rd0();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_exec();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_issue_ctrl.md
Name: cpu_issue_ctrl

Overview:
- Control-side sequencer that drives the CPU datapath control inputs from 32-bit R-type instruction words: register addresses, ALU select, shift amount and write enable.
- Accepts instructions over a valid/ready handshake and issues each one to the datapath for exactly one cycle.
- Captures the datapath's ALU result and zero flag and returns them over a valid/ready response channel.
- Sits between an instruction source (test driver or future fetch unit) and the CPU datapath.

Parameters:
- CNT_W, 16, width of the retired-instruction and illegal-instruction counters (saturating).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction word present on instr.
- instr  input  32  instruction word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct.
- instr_ready  output  1  block can accept an instruction.
- read_reg1  output  5  datapath read address 1 (rs).
- read_reg2  output  5  datapath read address 2 (rt).
- write_reg  output  5  datapath write address (rd).
- ALU_Sel  output  4  datapath ALU operation.
- Shamt  output  5  datapath shift amount.
- write_enable  output  1  datapath register write strobe.
- ALU_result  input  32  datapath ALU output.
- Zero_flag  input  1  datapath zero flag.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts the response.
- resp_data  output  32  captured ALU result; 0 for an illegal instruction.
- resp_zero  output  1  captured zero flag; 0 for an illegal instruction.
- resp_illegal  output  1  the instruction was illegal.
- retired_cnt  output  CNT_W  count of legal instructions issued.
- illegal_cnt  output  CNT_W  count of illegal instructions received.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high and has priority over all other activity.
  - On reset: state=IDLE.
  - All outputs go to 0, including the counters, instr_ready and write_enable.
  - Reset during EXEC must not produce write_enable=1 in the cycle after reset.
  - A pending response is discarded.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr into the instruction register and go to EXEC.
  - Datapath control outputs are 0 and write_enable=0.
- EXEC (exactly 1 cycle):
  - instr_ready=0.
  - Outputs are decoded combinationally from the latched instruction: read_reg1=rs, read_reg2=rt, write_reg=rd, Shamt=shamt.
  - write_enable=1 only if the instruction is legal and rd!=0. A write to rd=0 is suppressed but still counts as retired.
  - At the end of the cycle, capture ALU_result and Zero_flag into resp_data and resp_zero.
  - Increment retired_cnt or illegal_cnt, then go to RESP.
- Decode (opcode must be 6'h00, otherwise illegal), funct to ALU_Sel:
  - 6'h20 add -> 4'd0
  - 6'h22 sub -> 4'd1
  - 6'h24 and -> 4'd2
  - 6'h25 or -> 4'd3
  - 6'h26 xor -> 4'd4
  - 6'h27 nor -> 4'd5
  - 6'h00 sll -> 4'd6
  - 6'h02 srl -> 4'd7
  - 6'h03 sra -> 4'd8
  - 6'h2A slt -> 4'd9
  - Any other funct is illegal.
- Illegal instruction: ALU_Sel=0, write_enable=0, resp_data=0, resp_zero=0, resp_illegal=1.
- RESP:
  - resp_valid=1 and resp_* are held stable until resp_valid&&resp_ready.
  - On acceptance, go to IDLE. resp_valid drops in the next cycle.
  - instr_ready=0 while in RESP; no instruction is accepted in the same cycle as response acceptance.
- Throughput: at most one instruction per 3 cycles. Minimum latency from instruction accept to resp_valid is 2 cycles.
- Counters saturate at all-ones and do not wrap.
- instr and instr_valid are ignored outside IDLE. The source must hold them until accepted; instr may change freely after acceptance with no effect.
- Control outputs are registered or decoded from registered state only; no combinational path from instr to datapath outputs.

Test Plan:
- Reset: assert rst for 2 cycles mid-EXEC -> next cycle write_enable=0, resp_valid=0, both counters 0, instr_ready=1.
- Legal add: instr=32'h00221820 (rs=1, rt=2, rd=3, add), ALU_result driven 32'h5 in EXEC:
  - read_reg1=1, read_reg2=2, write_reg=3, ALU_Sel=0, write_enable=1 for exactly one cycle.
  - resp_data=5, resp_zero=0, retired_cnt=1.
- Shift: instr=32'h00021100 (sll rd=2, rt=2, shamt=4) -> Shamt=4, ALU_Sel=6, write_enable=1.
  - Zero_flag=1 in EXEC gives resp_zero=1.
- Illegal, rd=0 and backpressure:
  - opcode 6'h23 -> write_enable stays 0, resp_illegal=1, illegal_cnt=1.
  - instr=32'h00220020 (rd=0) -> write_enable=0, retired_cnt increments.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and resp_data stable, instr_ready=0.
  - Release -> IDLE the next cycle, instr_ready=1.
- Throughput: 4 back-to-back instructions with resp_ready=1 -> accepts spaced exactly 3 cycles apart, responses in order.
- Saturation: with CNT_W=2, issue 5 legal instructions -> retired_cnt=3.
